// File: rtl/segment_display_unit_if.sv
// ---------------------------------------------------------------------------
// segment_display_unit_if
//   Signal bundle between a digit source and the seven-segment display unit.
//
//   digit      [3:0]  value to display, 0-15
//   blank             all segments off while high
//   lamp_test         all segments on while high (overrides blank)
//   o_Segment  [6:0]  active-low segment drive, bit0=A ... bit6=G
//   o_Invalid         registered digit has no legal glyph
//
//   modport master : drives digit/blank/lamp_test, observes the outputs
//   modport slave  : the display unit itself
// ---------------------------------------------------------------------------
interface segment_display_unit_if;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [6:0] o_Segment;
  logic       o_Invalid;

  modport master (
    output digit,
    output blank,
    output lamp_test,
    input  o_Segment,
    input  o_Invalid
  );

  modport slave (
    input  digit,
    input  blank,
    input  lamp_test,
    output o_Segment,
    output o_Invalid
  );
endinterface : segment_display_unit_if

// File: rtl/segment_display_unit.sv
// ---------------------------------------------------------------------------
// segment_display_unit
//   Registered seven-segment decoder with lamp-test and blanking.
//   Output is the decode of the inputs sampled on the previous rising edge
//   (one cycle latency); there is no other state.
//
//   Priority: lamp_test > blank > digit decode.
//
//   Ports
//     clk    rising-edge system clock
//     reset  asynchronous, active-high; forces a blank display, o_Invalid=0
//     bus    segment_display_unit_if.slave
//              digit, blank, lamp_test  (inputs)
//              o_Segment (active-low, bit0=A..bit6=G), o_Invalid (outputs)
//
//   Configuration
//     SEGMENT_DISPLAY_HEX_EN  when defined, digits 10-15 show A,b,C,d,E,F.
//                             When undefined, they blank and flag o_Invalid.
// ---------------------------------------------------------------------------
module segment_display_unit (
  input  logic                  clk,
  input  logic                  reset,
  segment_display_unit_if.slave bus
);

  localparam logic [6:0] SEG_ALL_ON  = 7'h00;
  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

  logic [6:0] glyph;
  logic       glyph_valid;

  logic [6:0] seg_d;
  logic [6:0] seg_q;
  logic       invalid_d;
  logic       invalid_q;

  // Digit-to-glyph lookup, active-low segments.
  always_comb begin
    glyph       = SEG_ALL_OFF;
    glyph_valid = 1'b1;
    case (bus.digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
`ifdef SEGMENT_DISPLAY_HEX_EN
      4'd10:   glyph = 7'h08;
      4'd11:   glyph = 7'h03;
      4'd12:   glyph = 7'h46;
      4'd13:   glyph = 7'h21;
      4'd14:   glyph = 7'h06;
      4'd15:   glyph = 7'h0E;
      default: glyph = SEG_ALL_OFF;
`else
      // No glyph for 10-15 in decimal-only builds: show nothing, flag it.
      default: begin
        glyph       = SEG_ALL_OFF;
        glyph_valid = 1'b0;
      end
`endif
    endcase
  end

  // Override chain. Lamp test and blanking are deliberate display states,
  // so they never report an invalid digit.
  always_comb begin
    seg_d     = glyph;
    invalid_d = ~glyph_valid;
    if (bus.lamp_test) begin
      seg_d     = SEG_ALL_ON;
      invalid_d = 1'b0;
    end else if (bus.blank) begin
      seg_d     = SEG_ALL_OFF;
      invalid_d = 1'b0;
    end
  end

  // Reset acts on the output flops directly so the display blanks the
  // moment reset rises, without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q     <= SEG_ALL_OFF;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.o_Segment = seg_q;
  assign bus.o_Invalid = invalid_q;

endmodule : segment_display_unit

// File: tb/tb_segment_display_unit.sv
// ---------------------------------------------------------------------------
// tb_segment_display_unit
//   Directed and randomized checks of segment_display_unit. Inputs change
//   1 time unit after a rising edge; outputs are checked 1 time unit after
//   the following rising edge.
// ---------------------------------------------------------------------------
module tb_segment_display_unit;

  logic clk;
  logic reset;
  int   pass_count;
  int   check_count;

  segment_display_unit_if bus ();

  segment_display_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written glyph tables (active-low, bit0=A .. bit6=G).
  logic [6:0] dec_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] hex_tab [0:5] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference decode used by the random tracking test.
  function automatic logic [7:0] ref_decode(input logic [3:0] d,
                                            input logic b,
                                            input logic lt);
    logic [6:0] s;
    logic       inv;
    inv = 1'b0;
    if (lt) s = 7'h00;
    else if (b) s = 7'h7F;
    else if (d < 4'd10) s = dec_tab[d];
    else begin
`ifdef SEGMENT_DISPLAY_HEX_EN
      s = hex_tab[d - 4'd10];
`else
      s   = 7'h7F;
      inv = 1'b1;
`endif
    end
    return {s, inv};
  endfunction

  task automatic drive(input logic [3:0] d, input logic b, input logic lt);
    bus.digit     = d;
    bus.blank     = b;
    bus.lamp_test = lt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd8, 1'b0, 1'b0);
    #2;
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h7F, 1'b0})
      $display("FAIL reset_initial: got seg=%h inv=%b, expected seg=7f inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    // Held across clock edges with a decodable digit present.
    next_cycle();
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h7F, 1'b0})
      $display("FAIL reset_held: got seg=%h inv=%b, expected seg=7f inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    // Deassert between edges; first edge loads the current inputs.
    reset = 1'b0;
    drive(4'd2, 1'b0, 1'b0);
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h24, 1'b0})
      $display("FAIL reset_first_edge: got seg=%h inv=%b, expected seg=24 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    $display("reset: release then digit 2 -> seg=%h inv=%b", bus.o_Segment, bus.o_Invalid);
  endtask

  task automatic test_reset_mid_operation();
    drive(4'd8, 1'b0, 1'b0);
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h00, 1'b0})
      $display("FAIL reset_mid_pre: got seg=%h inv=%b, expected seg=00 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    #2;           // away from any edge
    reset = 1'b1;
    #1;
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h7F, 1'b0})
      $display("FAIL reset_mid_async: got seg=%h inv=%b, expected seg=7f inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    $display("reset_mid: digit 8 then async reset -> seg=%h inv=%b",
             bus.o_Segment, bus.o_Invalid);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h00, 1'b0})
      $display("FAIL reset_mid_recover: got seg=%h inv=%b, expected seg=00 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
  endtask

  task automatic test_decimal_sweep();
    logic [6:0] exp_seg;
    drive(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_seg = dec_tab[i];
      next_cycle();
      check_count++;
      if ({bus.o_Segment, bus.o_Invalid} !== {exp_seg, 1'b0})
        $display("FAIL decimal_%0d: got seg=%h inv=%b, expected seg=%h inv=0",
                 i, bus.o_Segment, bus.o_Invalid, exp_seg);
      else pass_count++;
      $display("decimal: digit %0d -> seg=%h inv=%b", i, bus.o_Segment, bus.o_Invalid);
      if (i < 9) bus.digit = 4'(i + 1);
    end
  endtask

  task automatic test_upper_values();
    logic [6:0] exp_seg;
    logic       exp_inv;
    drive(4'd10, 1'b0, 1'b0);
    for (int i = 10; i < 16; i++) begin
`ifdef SEGMENT_DISPLAY_HEX_EN
      exp_seg = hex_tab[i - 10];
      exp_inv = 1'b0;
`else
      exp_seg = 7'h7F;
      exp_inv = 1'b1;
`endif
      next_cycle();
      check_count++;
      if ({bus.o_Segment, bus.o_Invalid} !== {exp_seg, exp_inv})
        $display("FAIL upper_%0d: got seg=%h inv=%b, expected seg=%h inv=%b",
                 i, bus.o_Segment, bus.o_Invalid, exp_seg, exp_inv);
      else pass_count++;
      $display("upper: digit %0d -> seg=%h inv=%b", i, bus.o_Segment, bus.o_Invalid);
      if (i < 15) bus.digit = 4'(i + 1);
    end
  endtask

  task automatic test_priority();
    drive(4'd3, 1'b1, 1'b1);
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h00, 1'b0})
      $display("FAIL prio_lamp: got seg=%h inv=%b, expected seg=00 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    $display("priority: lamp+blank digit 3 -> seg=%h", bus.o_Segment);
    bus.lamp_test = 1'b0;
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h7F, 1'b0})
      $display("FAIL prio_blank: got seg=%h inv=%b, expected seg=7f inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    $display("priority: blank digit 3 -> seg=%h", bus.o_Segment);
    bus.blank = 1'b0;
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h30, 1'b0})
      $display("FAIL prio_digit: got seg=%h inv=%b, expected seg=30 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    $display("priority: digit 3 -> seg=%h", bus.o_Segment);
    // Blank and lamp test override an invalid digit as well.
    drive(4'd12, 1'b1, 1'b0);
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h7F, 1'b0})
      $display("FAIL prio_blank_upper: got seg=%h inv=%b, expected seg=7f inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
    drive(4'd15, 1'b0, 1'b1);
    next_cycle();
    check_count++;
    if ({bus.o_Segment, bus.o_Invalid} !== {7'h00, 1'b0})
      $display("FAIL prio_lamp_upper: got seg=%h inv=%b, expected seg=00 inv=0",
               bus.o_Segment, bus.o_Invalid);
    else pass_count++;
  endtask

  task automatic test_tracking();
    logic [3:0] prev_d;
    logic       prev_b;
    logic       prev_lt;
    logic [7:0] exp_v;
    int         errs;
    errs    = 0;
    prev_d  = 4'($urandom_range(0, 15));
    prev_b  = 1'b0;
    prev_lt = 1'b0;
    drive(prev_d, prev_b, prev_lt);
    for (int n = 0; n < 1000; n++) begin
      next_cycle();
      exp_v = ref_decode(prev_d, prev_b, prev_lt);
      check_count++;
      if ({bus.o_Segment, bus.o_Invalid} !== exp_v) begin
        errs++;
        $display("FAIL track_%0d: got seg=%h inv=%b, expected seg=%h inv=%b (digit=%0d blank=%b lamp=%b)",
                 n, bus.o_Segment, bus.o_Invalid, exp_v[7:1], exp_v[0], prev_d, prev_b, prev_lt);
      end else pass_count++;
      prev_d  = 4'($urandom_range(0, 15));
      prev_b  = ($urandom_range(0, 7) == 0);
      prev_lt = ($urandom_range(0, 7) == 0);
      drive(prev_d, prev_b, prev_lt);
    end
    $display("tracking: 1000 cycles, %0d errors", errs);
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    test_reset();
    test_decimal_sweep();
    test_upper_values();
    test_priority();
    test_reset_mid_operation();
    test_tracking();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_segment_display_unit
